// File: rtl/mem_fu_lsb_pkg.sv
// Shared definitions for the memory functional unit: MEM_FUNC opcodes and load-buffer entry states.
package mem_fu_lsb_pkg;

    typedef logic [3:0] mem_func_t;

    localparam mem_func_t MEM_LB           = 4'h0;
    localparam mem_func_t MEM_LH           = 4'h1;
    localparam mem_func_t MEM_LW           = 4'h2;
    localparam mem_func_t MEM_LOAD_DOUBLE  = 4'h3;
    localparam mem_func_t MEM_LBU          = 4'h4;
    localparam mem_func_t MEM_LHU          = 4'h5;
    localparam mem_func_t MEM_SB           = 4'h8;
    localparam mem_func_t MEM_SH           = 4'h9;
    localparam mem_func_t MEM_SW           = 4'hA;
    localparam mem_func_t MEM_STORE_DOUBLE = 4'hB;

    typedef logic [1:0] lb_state_t;

    localparam lb_state_t LB_FREE  = 2'd0;
    localparam lb_state_t LB_PEND  = 2'd1;
    localparam lb_state_t LB_READY = 2'd2;

    // Every store opcode has bit 3 set; all remaining codes are loads.
    function automatic logic func_is_store(input mem_func_t f);
        return f[3];
    endfunction

endpackage

// File: rtl/mem_fu_lsb_load_align.sv
// Load data alignment: picks the word (forwarded or from the line), then the byte/half, and extends it.
module mem_fu_lsb_load_align
    import mem_fu_lsb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LINE_BITS = 64
) (
    input  logic [LINE_BITS-1:0] line_i,
    input  logic                 fwd_valid_i,
    input  logic [XLEN-1:0]      fwd_data_i,
    input  logic [2:0]           addr_lo_i,
    input  mem_func_t            func_i,
    output logic [XLEN-1:0]      data_o
);

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(XLEN-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(XLEN-16){sgn & h[15]}}, h};
    endfunction

    logic [XLEN-1:0] word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Forwarded data already is the addressed word, so the line-word select is bypassed.
    assign word = fwd_valid_i ? fwd_data_i
                : (addr_lo_i[2] ? line_i[2*XLEN-1:XLEN] : line_i[XLEN-1:0]);

    always_comb begin
        case (addr_lo_i[1:0])
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (func_i)
            MEM_LB:  data_o = ext8(byte_sel, 1'b1);
            MEM_LBU: data_o = ext8(byte_sel, 1'b0);
            MEM_LH:  data_o = ext16(half_sel, 1'b1);
            MEM_LHU: data_o = ext16(half_sel, 1'b0);
            default: data_o = word;
        endcase
    end

endmodule

// File: rtl/mem_fu_lsb.sv
// Memory functional unit: address generation, store hand-off, LQ_DEPTH-entry load buffer and CDB arbitration.
// Optional ISSUE_BYPASS_EN: a load issued while nothing is PEND is probed in its own issue cycle.
module mem_fu_lsb
    import mem_fu_lsb_pkg::*;
#(
    parameter int LQ_DEPTH  = 4,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 6,
    parameter int SQ_IDX_W  = 3,
    parameter int LINE_BITS = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  mem_func_t            issue_func,
    input  logic [XLEN-1:0]      issue_rs1,
    input  logic [XLEN-1:0]      issue_rs2,
    input  logic [XLEN-1:0]      issue_imm,
    input  logic [SQ_IDX_W-1:0]  issue_sq_idx,
    input  logic [TAG_W-1:0]     issue_dest_tag,
    output logic                 sq_entry_valid,
    output logic [XLEN-1:0]      sq_entry_addr,
    output logic [XLEN-1:0]      sq_entry_data,
    output logic [SQ_IDX_W-1:0]  sq_entry_idx,
    output logic                 sq_lookup_valid,
    output logic [XLEN-1:0]      sq_lookup_addr,
    output logic [SQ_IDX_W-1:0]  sq_lookup_tail,
    input  logic                 sq_fwd_valid,
    input  logic [XLEN-1:0]      sq_fwd_data,
    output logic                 dc_req_valid,
    output logic [XLEN-1:0]      dc_req_addr,
    input  logic                 dc_resp_valid,
    input  logic [LINE_BITS-1:0] dc_resp_data,
    output logic                 cdb_request,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [XLEN-1:0]      cdb_data,
    input  logic                 cdb_grant
);

    localparam int IDX_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     addr;
        logic [SQ_IDX_W-1:0] sq_tail;
        mem_func_t           func;
        logic [XLEN-1:0]     data;
    } lb_entry_t;

    lb_state_t state_q [LQ_DEPTH];
    lb_state_t state_d [LQ_DEPTH];
    lb_entry_t ent_q   [LQ_DEPTH];
    lb_entry_t ent_d   [LQ_DEPTH];
    idx_t      rr_q, rr_d;
    logic      sd_valid_q, sd_valid_d;
    logic      lock_valid_q, lock_valid_d;
    logic      lock_store_q, lock_store_d;
    idx_t      lock_idx_q, lock_idx_d;

    logic      sel_valid, sel_store, grant_load;
    idx_t      sel_idx;

    // A presented result is latched until granted so tag/data never change under the arbiter.
    always_comb begin
        sel_valid = 1'b0;
        sel_store = 1'b0;
        sel_idx   = '0;
        if (lock_valid_q) begin
            sel_valid = 1'b1;
            sel_store = lock_store_q;
            sel_idx   = lock_idx_q;
        end else if (sd_valid_q) begin
            sel_valid = 1'b1;
            sel_store = 1'b1;
        end else begin
            for (int i = LQ_DEPTH - 1; i >= 0; i--) begin
                if (state_q[i] == LB_READY) begin
                    sel_valid = 1'b1;
                    sel_idx   = idx_t'(i);
                end
            end
        end
    end

    assign grant_load  = cdb_grant && sel_valid && !sel_store;
    assign cdb_request = sel_valid;
    assign cdb_tag     = (sel_valid && !sel_store) ? ent_q[sel_idx].tag  : '0;
    assign cdb_data    = (sel_valid && !sel_store) ? ent_q[sel_idx].data : '0;

    logic [LQ_DEPTH-1:0] avail;
    logic                any_avail, any_pend;
    idx_t                alloc_idx;

    // An entry granted this cycle counts as free so it can be reallocated at the same edge.
    always_comb begin
        avail     = '0;
        any_avail = 1'b0;
        any_pend  = 1'b0;
        alloc_idx = '0;
        for (int i = LQ_DEPTH - 1; i >= 0; i--) begin
            avail[i] = (state_q[i] == LB_FREE) || (grant_load && sel_idx == idx_t'(i));
            if (avail[i]) begin
                any_avail = 1'b1;
                alloc_idx = idx_t'(i);
            end
            if (state_q[i] == LB_PEND) any_pend = 1'b1;
        end
    end

    logic            issue_fire, store_fire, load_fire;
    logic [XLEN-1:0] eff_addr;

    assign issue_ready = !reset && !flush && any_avail && !sd_valid_q;
    assign issue_fire  = issue_valid && issue_ready;
    assign store_fire  = issue_fire && func_is_store(issue_func);
    assign load_fire   = issue_fire && !func_is_store(issue_func);
    assign eff_addr    = issue_rs1 + issue_imm;

    assign sq_entry_valid = store_fire;
    assign sq_entry_addr  = store_fire ? eff_addr     : '0;
    assign sq_entry_data  = store_fire ? issue_rs2    : '0;
    assign sq_entry_idx   = store_fire ? issue_sq_idx : '0;

    logic rr_found;
    idx_t rr_idx;
    int   scan;

    // Round-robin search for the first PEND entry at or after rr_q.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan     = 0;
        for (int k = LQ_DEPTH - 1; k >= 0; k--) begin
            scan = int'(rr_q) + k;
            if (scan >= LQ_DEPTH) scan = scan - LQ_DEPTH;
            if (state_q[idx_t'(scan)] == LB_PEND) begin
                rr_found = 1'b1;
                rr_idx   = idx_t'(scan);
            end
        end
    end

    logic bypass;
`ifdef ISSUE_BYPASS_EN
    assign bypass = load_fire && !any_pend;
`else
    assign bypass = 1'b0;
`endif

    logic                probe_valid, probe_hit;
    logic [XLEN-1:0]     probe_addr, align_data;
    logic [SQ_IDX_W-1:0] probe_tail;
    mem_func_t           probe_func;

    assign probe_valid = rr_found || bypass;
    assign probe_addr  = bypass ? eff_addr     : ent_q[rr_idx].addr;
    assign probe_tail  = bypass ? issue_sq_idx : ent_q[rr_idx].sq_tail;
    assign probe_func  = bypass ? issue_func   : ent_q[rr_idx].func;
    assign probe_hit   = probe_valid && (sq_fwd_valid || dc_resp_valid);

    assign sq_lookup_valid = probe_valid;
    assign sq_lookup_addr  = probe_valid ? probe_addr : '0;
    assign sq_lookup_tail  = probe_valid ? probe_tail : '0;
    assign dc_req_valid    = probe_valid && !sq_fwd_valid;
    assign dc_req_addr     = probe_valid ? probe_addr : '0;

    mem_fu_lsb_load_align #(
        .XLEN      (XLEN),
        .LINE_BITS (LINE_BITS)
    ) u_align (
        .line_i      (dc_resp_data),
        .fwd_valid_i (sq_fwd_valid),
        .fwd_data_i  (sq_fwd_data),
        .addr_lo_i   (probe_addr[2:0]),
        .func_i      (probe_func),
        .data_o      (align_data)
    );

    // Probe result, then grant release, then allocation: free-before-alloc lets a slot turn over in one edge.
    always_comb begin
        state_d    = state_q;
        ent_d      = ent_q;
        rr_d       = rr_q;
        sd_valid_d = sd_valid_q;
        if (rr_found) begin
            rr_d = (rr_idx == idx_t'(LQ_DEPTH - 1)) ? '0 : rr_idx + idx_t'(1);
            if (probe_hit) begin
                state_d[rr_idx]    = LB_READY;
                ent_d[rr_idx].data = align_data;
            end
        end
        if (cdb_grant && sel_valid) begin
            if (sel_store) sd_valid_d = 1'b0;
            else           state_d[sel_idx] = LB_FREE;
        end
        if (store_fire) sd_valid_d = 1'b1;
        if (load_fire) begin
            state_d[alloc_idx] = (bypass && probe_hit) ? LB_READY : LB_PEND;
            ent_d[alloc_idx]   = '{tag:     issue_dest_tag,
                                   addr:    eff_addr,
                                   sq_tail: issue_sq_idx,
                                   func:    issue_func,
                                   data:    align_data};
        end
        lock_valid_d = sel_valid && !cdb_grant;
        lock_store_d = sel_store;
        lock_idx_d   = sel_idx;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < LQ_DEPTH; i++) state_q[i] <= LB_FREE;
            rr_q         <= '0;
            sd_valid_q   <= 1'b0;
            lock_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            sd_valid_q   <= sd_valid_d;
            lock_valid_q <= lock_valid_d;
        end
        lock_store_q <= lock_store_d;
        lock_idx_q   <= lock_idx_d;
    end

    always_ff @(posedge clock) begin
        ent_q <= ent_d;
    end

endmodule
